// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int DEPTH          = 32;
    localparam int CNT_W          = 6;
    localparam int ADDR_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // A load request is legal only for 1..DEPTH words.
    function automatic logic len_ok(input logic [CNT_W-1:0] len);
        return (len != '0) && (len <= CNT_W'(DEPTH));
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Control, byte-stream and memory write-port bundle of the instruction loader.
// Latency: n/a (wiring only).
// Backpressure: byte_ready_o qualifies byte_valid_i; no byte moves without both.
interface instr_mem_loader_if;
    import instr_loader_pkg::*;

    logic                 start_i;
    logic [CNT_W-1:0]     len_i;
    logic                 byte_valid_i;
    logic [7:0]           byte_i;
    logic                 byte_ready_o;
    logic                 mem_we_o;
    logic [ADDR_W-1:0]    mem_addr_o;
    logic [WORD_W-1:0]    mem_data_o;
    logic                 cpu_hold_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    // Boot/test source side: issues the load and supplies bytes.
    modport master (
        output start_i, len_i, byte_valid_i, byte_i,
        input  byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               cpu_hold_o, busy_o, done_o, err_o
    );

    // Loader side.
    modport slave (
        input  start_i, len_i, byte_valid_i, byte_i,
        output byte_ready_o, mem_we_o, mem_addr_o, mem_data_o,
               cpu_hold_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/byte_packer.sv
// Packs bytes big-endian into a word: first byte lands in the top lane.
// Latency: word_o/word_full_o are combinational with the 4th byte; state updates on the edge.
// Backpressure: none; shifts only when shift_en_i is asserted by the owner.
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);

    // Only the first three bytes need storage; the fourth is taken straight
    // from byte_i in the cycle it is accepted.
    logic [WORD_W-9:0] shreg_q, shreg_d;
    logic [1:0]        cnt_q, cnt_d;

    // Next-state: clear wins over shift; the byte counter wraps 3->0 by itself.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shreg_d = {shreg_q[WORD_W-17:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Shift register and byte counter state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o      = {shreg_q, byte_i};
    assign word_full_o = shift_en_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte stream into the instruction memory as big-endian words at sequential addresses.
// Latency: 4th byte accepted at edge N -> mem_we_o in cycle N+1 -> done_o in N+2 for the last word.
// Backpressure: byte_ready_o only in RECV; bytes offered in any other state wait, nothing is lost.
module instr_mem_loader
    import instr_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    instr_mem_loader_if.slave  bus
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    word_idx_q, word_idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                err_q, err_d;

    logic                byte_ready;
    logic                mem_we;
    logic                busy;
    logic                done;

    logic                start_ok;
    logic                xfer;
    logic                last_word;
    logic [WORD_W-1:0]   packed_word;
    logic                word_full;

    assign start_ok  = (state_q == ST_IDLE) && bus.start_i && len_ok(bus.len_i);
    assign xfer      = bus.byte_valid_i && byte_ready;
    assign last_word = (word_idx_q == (len_q - CNT_W'(1)));

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_ok),
        .shift_en_i  (xfer),
        .byte_i      (bus.byte_i),
        .word_o      (packed_word),
        .word_full_o (word_full)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one WRITE cycle per completed word, DONE after the last.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start_ok)  state_d = ST_RECV;
            ST_RECV:  if (word_full) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_DONE : ST_RECV;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: hold/busy cover RECV and WRITE and drop in the DONE cycle.
    always_comb begin
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
            end
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: length latch, word index, write-port capture, error pulse.
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = (state_q == ST_IDLE) && bus.start_i && !len_ok(bus.len_i);
        if (start_ok) begin
            len_d      = bus.len_i;
            word_idx_d = '0;
        end
        // Capture address and data as the word completes so both are stable
        // throughout the WRITE cycle and held afterwards.
        if (state_q == ST_RECV && word_full) begin
            addr_d = {{(ADDR_W-CNT_W-2){1'b0}}, word_idx_q, 2'b00};
            data_d = packed_word;
        end
        if (state_q == ST_WRITE && !last_word) begin
            word_idx_d = word_idx_q + CNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            len_q      <= '0;
            word_idx_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    assign bus.byte_ready_o = byte_ready;
    assign bus.mem_we_o     = mem_we;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = data_q;
    assign bus.cpu_hold_o   = busy;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.err_o        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;
    import instr_loader_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_mem_loader_if bus();

    instr_mem_loader dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Observer: records writes into a memory image and counts pulses.
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] mem_img[DEPTH];
    int done_cnt = 0, err_cnt = 0, we_cnt = 0;
    int last_we_cyc = -100, done_cyc = -100, last_xfer_cyc = -100, word_bytes = 0;

    always @(negedge clk) begin
        if (rst) begin
            word_bytes = 0;
        end else begin
            if (bus.byte_valid_i && bus.byte_ready_o) begin
                word_bytes++;
                last_xfer_cyc = cyc;
            end
            if (bus.mem_we_o) begin
                chk("we_latency", cyc - last_xfer_cyc, 1);
                chk("bytes_per_word", word_bytes, 4);
                chk("hold_in_write", {31'd0, bus.cpu_hold_o}, 1);
                word_bytes = 0;
                we_cnt++;
                wq_addr.push_back(bus.mem_addr_o);
                wq_data.push_back(bus.mem_data_o);
                mem_img[bus.mem_addr_o[6:2]] = bus.mem_data_o;
                last_we_cyc = cyc;
            end
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", {30'd0, bus.busy_o, bus.cpu_hold_o}, 0);
            end
            if (bus.err_o) err_cnt++;
        end
    end

    task automatic do_start(input int len);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.len_i   = 6'(len);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    // mode 0: valid held high, 1: valid toggles, 2: random valid.
    // pulse_at >= 0 drives a stray start_i while that byte is offered.
    task automatic feed(input logic [7:0] b[$], input int mode, input int pulse_at);
        int  idx   = 0;
        int  guard = 0;
        bit  tog   = 1'b1;
        bit  v;
        bit  xfer;
        while (idx < b.size() && guard < 3000) begin
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.byte_valid_i = v;
            bus.byte_i       = b[idx];
            if (idx == pulse_at) begin
                bus.start_i = 1'b1;
                bus.len_i   = 6'd5;
            end else begin
                bus.start_i = 1'b0;
            end
            @(negedge clk);
            xfer = v && bus.byte_ready_o;
            @(posedge clk); #1;
            if (xfer) idx++;
            guard++;
        end
        bus.byte_valid_i = 1'b0;
        bus.start_i      = 1'b0;
        if (idx < b.size()) chk("feed_timeout", idx, b.size());
    endtask

    // Full load: expected writes are word i at byte address 4*i, holding
    // bytes 4i..4i+3 with the earliest byte most significant.
    task automatic run_load(input string tag, input logic [7:0] b[$], input int mode, input int pulse_at);
        int len = b.size() / 4;
        int d0  = done_cnt;
        int g   = 0;
        wq_addr.delete();
        wq_data.delete();
        do_start(len);
        feed(b, mode, pulse_at);
        while (done_cnt == d0 && g < 20) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_we_count"}, wq_addr.size(), len);
        for (int i = 0; i < len && i < wq_addr.size(); i++) begin
            chk({tag, "_addr"}, wq_addr[i], 32'(i * 4));
            chk({tag, "_data"}, wq_data[i], {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
        end
        chk({tag, "_done_after_we"}, done_cyc - last_we_cyc, 1);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {31'd0, bus.busy_o}, 0);
        chk({tag, "_idle_ready"}, {31'd0, bus.byte_ready_o}, 0);
    endtask

    initial begin
        logic [7:0] b[$];
        logic [7:0] t1[8];
        int e0, w0, d0;

        bus.start_i      = 1'b0;
        bus.len_i        = '0;
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.byte_ready_o}, 0);
        chk("rst_we",    {31'd0, bus.mem_we_o}, 0);
        chk("rst_addr",  bus.mem_addr_o, 0);
        chk("rst_data",  bus.mem_data_o, 0);
        chk("rst_busy",  {31'd0, bus.busy_o}, 0);
        chk("rst_hold",  {31'd0, bus.cpu_hold_o}, 0);
        chk("rst_done",  {31'd0, bus.done_o}, 0);
        chk("rst_err",   {31'd0, bus.err_o}, 0);

        // Test 1: known two-word program, bytes back to back.
        t1 = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h00, 8'h22, 8'h18, 8'h20};
        b.delete();
        foreach (t1[i]) b.push_back(t1[i]);
        run_load("t1", b, 0, -1);
        chk("t1_w0_const", wq_data[0], 32'h8C010004);
        chk("t1_w1_const", wq_data[1], 32'h00221820);

        // Test 2: one word with valid toggling.
        b.delete();
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        w0 = we_cnt;
        run_load("t2", b, 1, -1);
        chk("t2_one_we", we_cnt - w0, 1);

        // Test 3: illegal lengths are rejected.
        e0 = err_cnt;
        w0 = we_cnt;
        do_start(0);
        @(negedge clk);
        chk("t3_err_len0", {31'd0, bus.err_o}, 1);
        chk("t3_busy_len0", {31'd0, bus.busy_o}, 0);
        @(negedge clk);
        chk("t3_err_pulse0", {31'd0, bus.err_o}, 0);
        do_start(33);
        @(negedge clk);
        chk("t3_err_len33", {31'd0, bus.err_o}, 1);
        chk("t3_busy_len33", {31'd0, bus.busy_o}, 0);
        repeat (3) @(negedge clk);
        chk("t3_err_count", err_cnt - e0, 2);
        chk("t3_no_we", we_cnt - w0, 0);
        chk("t3_idle_ready", {31'd0, bus.byte_ready_o}, 0);

        // Test 4: full depth, each byte equals its word index.
        b.delete();
        for (int w = 0; w < DEPTH; w++)
            for (int k = 0; k < 4; k++) b.push_back(8'(w));
        run_load("t4", b, 0, -1);
        chk("t4_last_addr", wq_addr[DEPTH-1], 32'h7C);

        // Test 5: reset two bytes into word 1 of a three-word load.
        b.delete();
        for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
        w0 = we_cnt;
        d0 = done_cnt;
        do_start(3);
        feed(b, 0, -1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", {31'd0, bus.busy_o}, 0);
        chk("t5_hold", {31'd0, bus.cpu_hold_o}, 0);
        chk("t5_ready", {31'd0, bus.byte_ready_o}, 0);
        chk("t5_one_we", we_cnt - w0, 1);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_word0_kept", mem_img[0], {b[0], b[1], b[2], b[3]});
        b.delete();
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        run_load("t5_fresh", b, 0, -1);

        // Test 6: stray start pulse during RECV must not change length.
        b.delete();
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
        run_load("t6", b, 0, 2);

        // Randomized loads with random valid gaps.
        for (int r = 0; r < 6; r++) begin
            int len = $urandom_range(1, 8);
            b.delete();
            for (int i = 0; i < 4 * len; i++) b.push_back(8'($urandom));
            run_load("rnd", b, 2, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1);
    end

endmodule
